// File: rtl/segscan.sv
// Scan controller for a 4-digit common-anode 7-segment display: one digit per slot,
// blanking at the start of each slot, double-buffered value, optional leading-zero blanking.
module segscan #(
  parameter int CLK_DIV   = 12500,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [15:0] wdata,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  output logic [3:0]  nibble,
  input  logic [6:0]  segs_in,
  output logic [7:0]  seg_out,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic {BLANK, SHOW} state_t;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   display;
  logic [15:0]   shadow;
  logic [3:0]    dp;
  logic [3:0]    shadow_dp;
  logic          pending;

  state_t state;
  logic   slot_end;
  logic   frame_end;
  logic   blank_digit;
  logic   show;

  // Slot phase is a pure function of the counter, so state needs no flop of its own.
  always_comb begin
    state     = (cnt < CW'(BLANK_CYC)) ? BLANK : SHOW;
    slot_end  = (cnt == CW'(CLK_DIV - 1));
    frame_end = slot_end && (idx == 2'd3);
  end

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    blank_digit = 1'b0;
    if (lzb_en) begin
      case (idx)
        2'd1:    blank_digit = (display[15:4]  == 12'h000);
        2'd2:    blank_digit = (display[15:8]  == 8'h00);
        2'd3:    blank_digit = (display[15:12] == 4'h0);
        default: blank_digit = 1'b0;
      endcase
    end
    show = (state == SHOW) && !blank_digit;
  end

  assign nibble     = display[{idx, 2'b00} +: 4];
  assign frame_tick = frame_end;

  // NOTE: every register here is plain state (no memory arrays), so all of it takes the
  // asynchronous reset; a reset mid-slot restarts the scan at digit 0 in BLANK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= 2'd0;
      display   <= 16'h0000;
      shadow    <= 16'h0000;
      dp        <= 4'h0;
      shadow_dp <= 4'h0;
      pending   <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;

      if (we) begin
        shadow    <= wdata;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end

      // NOTE: non-blocking assignments let the later frame-boundary clear of pending
      // override the write's set above within the same cycle; last assignment wins.
      if (frame_end) begin
        if (we) begin
          display <= wdata;
          dp      <= dp_in;
          pending <= 1'b0;
        end else if (pending) begin
          display <= shadow;
          dp      <= shadow_dp;
          pending <= 1'b0;
        end
      end
    end
  end

  // Pins are driven only from flops, one cycle behind the slot phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= 8'h00;
      an      <= 4'b1111;
    end else if (show) begin
      seg_out <= {dp[idx], segs_in};
      an      <= ~(4'b0001 << idx);
    end else begin
      seg_out <= 8'h00;
      an      <= 4'b1111;
    end
  end

endmodule

// File: doc/segscan.md
Name: segscan

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Holds a 16-bit display value and scans one digit at a time. It presents each digit's 4-bit code on `nibble` to the team's existing hex-to-segment decoder, then registers the decoder's 7-bit `segs` result back in, together with the decimal point and the anode select.
- Sits between the CPU-side I/O register write strobe and the board display pins. It adds a blanking interval between digits (anti-ghosting), double-buffered updates (tear-free) and optional leading-zero blanking.

Parameters:
- CLK_DIV, 12500, clk cycles per digit slot (4 kHz slot rate at 50 MHz); must satisfy CLK_DIV > BLANK_CYC.
- BLANK_CYC, 64, cycles at the start of each slot with all anodes off; must be >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write strobe, one cycle, loads wdata/dp_in into shadow
- wdata  in  16  new display value; digit k = wdata[4k+3:4k], digit 0 rightmost
- dp_in  in  4  decimal point per digit, bit k = digit k
- lzb_en  in  1  leading-zero blanking enable (level, sampled live)
- nibble  out  4  current digit code, to decoder input
- segs_in  in  7  decoder output (bit0=a .. bit6=g, active high)
- seg_out  out  8  {dp, g..a} to pins, active high, registered
- an  out  4  anode selects, active low, registered
- frame_tick  out  1  one-cycle pulse at end of the digit-3 slot

Behaviour:
- One clock, asynchronous active-low reset.
- Reset values: an=4'b1111, seg_out=0, frame_tick=0, display=0, shadow=0, dp regs=0, pending=0, idx=0, cnt=0, state=BLANK; nibble=0.
- Slot counter cnt runs 0..CLK_DIV-1 and wraps. The state is BLANK while cnt < BLANK_CYC and SHOW otherwise.
- At cnt==CLK_DIV-1:
  - idx advances 0→1→2→3→0.
  - When idx==3 (frame boundary), frame_tick pulses that cycle.
  - At the frame boundary, if pending=1: display<=shadow, dp<=shadow_dp, pending<=0.
- nibble is combinational: display[4*idx+3 : 4*idx]. It is valid for the whole slot, so the decoder has settled before SHOW.
- Registered outputs, updated every cycle:
  - In BLANK, or when the digit is blanked: seg_out<=0, an<=4'b1111.
  - In SHOW: seg_out<={dp[idx], segs_in}, an<=~(4'b0001<<idx).
  - Pin response lags the state by exactly 1 cycle.
- Leading-zero blanking:
  - Applies only when lzb_en=1.
  - Digit k>0 is blanked if display digits k..3 are all zero.
  - A blanked digit keeps its anode off and its dp suppressed.
  - Digit 0 is never blanked.
- Writes:
  - we=1 sets shadow<=wdata, shadow_dp<=dp_in, pending<=1. The visible display is unchanged until the next frame boundary.
  - Back-to-back writes: last one wins.
- we coincident with the frame boundary: the incoming write bypasses directly. display<=wdata, dp<=dp_in, shadow updated, pending<=0.
- rst_n asserted mid-slot or mid-frame: all state returns immediately and asynchronously to reset values; scanning restarts at digit 0, BLANK.
- No output glitches: seg_out and an come straight from flops.

Test Plan:
Bench uses CLK_DIV=8, BLANK_CYC=2.
- Reset release, no writes:
  - Digit 0 slot: an=1111 for cycles 1-2 after the slot start; then an=1110 and seg_out=8'h3F (zero) for 6 cycles.
  - Digit 1 slot: an=1101 and seg_out=8'h3F in its SHOW window.
  - frame_tick pulses every 32 cycles.
- we with wdata=16'h12AF, dp_in=4'b0100 mid-frame:
  - display unchanged until frame_tick.
  - Next frame: nibble sequence F,A,2,1.
  - Digit 2 slot: seg_out=8'hDB (dp set, "2"); digit 3 slot: seg_out=8'h06.
- lzb_en=1 with value 16'h0005:
  - Only digit 0 shows (an=1110, seg_out=8'h6D); slots 1-3 keep an=1111 throughout.
  - Value 16'h0000 with lzb_en=1: digit 0 shows 8'h3F.
- we in the exact cycle of frame_tick with wdata=16'hBEEF: the next slot (digit 0) already shows "F" (seg_out=8'h71), with no extra frame of delay.
- Two writes, 16'h1111 then 16'h2222, within one frame: next frame shows all "2" (8'h5B); "1" never appears.
- rst_n pulsed low during the digit-2 SHOW window:
  - an=1111 and seg_out=0 asynchronously, while rst_n is low.
  - After release: display=0; scan restarts at digit 0 with 2 blank cycles.
